signal_freq_meter: RTL
======================

// Module: signal_freq_meter
// PURPOSE
//  Measures the period of one external square wave, e.g. a looped-back silly2 divided clock, in clk cycles.
//  Classifies the result as divide-by-2..256 (div_code 0..7) or as no match.
//  Receive-side checker for the divided-clock signal generator; sits beside it in the top-level.
//  One measurement per start pulse; results held until the next done.
// PARAMETERS
//  CNT_W    12    width of period counter/result (bits)
//  TIMEOUT  4095  max clk cycles per measurement before abort; must be < 2**CNT_W
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst_n       in   1      asynchronous active-low reset
//  sig_in      in   1      external square wave, asynchronous to clk
//  start       in   1      1-cycle request; ignored while busy=1
//  busy        out  1      high from cycle after accepted start until done
//  done        out  1      1-cycle pulse when period/div_code/div_match/timeout update
//  period      out  CNT_W  measured rising-edge to rising-edge period, clk cycles
//  div_code    out  3      log2(period)-1 when div_match=1, else 0
//  div_match   out  1      period is exactly 2**(div_code+1), range 2..256
//  timeout     out  1      last measurement aborted (no edge pair within TIMEOUT)
// BEHAVIOUR
//  Reset, async on rst_n low: state IDLE; counter, busy, done, period, div_code, div_match, timeout all 0.
//  Reset mid-measurement discards the measurement; no done.
//  sig_in passes a 2-FF synchronizer. rise is asserted when the synced value is 1 and the prior synced value was 0.
//  rise lags the pin by 2-3 clks. The lag is constant, so the period is unaffected.
//  FSM states: IDLE, ARM, MEAS, DONE.
//  IDLE: start=1 -> ARM, cnt<=0, busy<=1.
//  ARM: rise -> MEAS, cnt<=1. Otherwise cnt<=cnt+1.
//  MEAS: rise -> DONE, period<=cnt. Otherwise cnt<=cnt+1.
//  Counter semantics: cnt equals the number of clks since the first rise. An edge P clks later captures period=P.
//  ARM/MEAS with cnt==TIMEOUT and no rise -> DONE with timeout<=1 and period<=TIMEOUT.
//  rise in the same cycle as cnt==TIMEOUT: rise wins, normal capture.
//  DONE lasts exactly 1 cycle: done=1, busy<=0, then IDLE. A start in DONE is ignored.
//  div_match/div_code are computed combinationally from the captured count.
//  They are registered together with period, so all result outputs change only in the done cycle.
//  A timeout forces div_match=0 and div_code=0.
//  A period of 1 is impossible after the synchronizer. Any value other than 2,4,..,256 gives div_match=0.
//  Outputs hold between measurements. start does not clear them.
// CONFIGURATION
//  MULTI_PERIOD_EN defined: MEAS stays active across 4 consecutive rises.
//   An internal CNT_W+2-bit accumulator keeps counting and is never reset between rises.
//   The 4th rise captures period<=acc>>2; the remainder is dropped.
//   div_match additionally requires acc[1:0]==0.
//   The timeout compare uses the accumulator against 4*TIMEOUT.
//  MULTI_PERIOD_EN undefined: single-period measurement as above; no accumulator or period index.
// STRUCTURE
//  Package signal_meter_pkg:
//   state enum {IDLE, ARM, MEAS, DONE}
//   DIV_CODE_W=3
//   NPER=4 (multi-period count)
//   MIN_DIV_LOG2=1, MAX_DIV_LOG2=8
//  Sub-module sig_sync_rise: 2-FF synchronizer plus rising-edge detect.
//   Ports: clk, rst_n, d, q_sync, rise.
//  The top holds the FSM, counter and classifier.
// TESTING
//  1 sig_in=clk/2 square wave, start -> done within 8 clks; period=2, div_code=0, div_match=1, timeout=0.
//  2 sig_in=clk/256 -> period=256, div_code=7, div_match=1.
//    Repeat for all 8 silly2 outputs, rst_n released together with the generator.
//  3 sig_in held 0, TIMEOUT=4095, start -> done after 4096..4098 clks; timeout=1, period=4095, div_match=0.
//  4 sig_in period 6 (3 high / 3 low) -> period=6, div_match=0, div_code=0.
//    Under MULTI_PERIOD_EN, jittered periods 7,8,9,8 -> period=8, div_match=1, div_code=2.
//  5 start pulsed every cycle during a measurement -> exactly one done; results match the first measurement.
//  6 rst_n pulsed low mid-MEAS (async, between clk edges) -> outputs 0 immediately, no done.
//    A new start then measures correctly.

Source files
------------

// File: rtl/signal_meter_pkg.sv
// Shared types, constants and the power-of-two period classifier for signal_freq_meter.
package signal_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        DONE
    } meter_state_t;

    localparam int DIV_CODE_W   = 3;
    localparam int NPER         = 4;
    localparam int NPER_LOG2    = $clog2(NPER);
    localparam int MIN_DIV_LOG2 = 1;
    localparam int MAX_DIV_LOG2 = 8;

    typedef struct packed {
        logic                  match;
        logic [DIV_CODE_W-1:0] code;
    } div_class_t;

    // Only exact powers of two from 2 to 256 match; code is log2(period)-1.
    function automatic div_class_t classify_period(input logic [31:0] p);
        div_class_t r;
        r = '0;
        for (int k = MIN_DIV_LOG2; k <= MAX_DIV_LOG2; k++) begin
            if (p == (32'd1 << k)) begin
                r.match = 1'b1;
                r.code  = DIV_CODE_W'(k - MIN_DIV_LOG2);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sig_sync_rise.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module sig_sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign q_sync = r_sync;
    assign rise   = r_sync & ~r_prev;

endmodule

// File: rtl/signal_freq_meter.sv
// Measures the period of an external square wave in clk cycles and classifies it as divide-by-2..256.
// Define MULTI_PERIOD_EN to average over NPER consecutive periods instead of measuring one.
module signal_freq_meter
    import signal_meter_pkg::*;
#(
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sig_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      period,
    output logic [DIV_CODE_W-1:0] div_code,
    output logic                  div_match,
    output logic                  timeout
);

`ifdef MULTI_PERIOD_EN
    localparam int               ACC_W = CNT_W + NPER_LOG2;
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(NPER * TIMEOUT);
`else
    localparam int               ACC_W = CNT_W;
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(TIMEOUT);
`endif

    meter_state_t     r_state;
    meter_state_t     w_state_nxt;
    logic [ACC_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_cnt_nxt;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_period;
    logic [DIV_CODE_W-1:0] r_div_code;
    logic             r_div_match;
    logic             r_timeout;

    logic             w_sig_sync;
    logic             w_rise_raw;
    logic             w_rise;
    logic             w_capture;
    logic             w_abort;
    logic             w_last_rise;
    logic             w_exact;
    logic [CNT_W-1:0] w_result;
    div_class_t       w_class;

    sig_sync_rise u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (sig_in),
        .q_sync (w_sig_sync),
        .rise   (w_rise_raw)
    );

    assign w_rise = w_rise_raw & w_sig_sync;

`ifdef MULTI_PERIOD_EN
    logic [NPER_LOG2-1:0] r_idx;
    logic [NPER_LOG2-1:0] w_idx_nxt;

    // The accumulator runs across all NPER periods; the average drops the remainder.
    assign w_last_rise = (r_idx == NPER_LOG2'(NPER - 1));
    assign w_result    = CNT_W'(r_cnt >> NPER_LOG2);
    assign w_exact     = (r_cnt[NPER_LOG2-1:0] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else begin
            r_idx <= w_idx_nxt;
        end
    end
`else
    assign w_last_rise = 1'b1;
    assign w_result    = r_cnt;
    assign w_exact     = 1'b1;
`endif

    assign w_class = classify_period(32'(w_result));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rise takes priority over the timeout check in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
`ifdef MULTI_PERIOD_EN
        w_idx_nxt   = r_idx;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ARM;
                    w_cnt_nxt   = '0;
`ifdef MULTI_PERIOD_EN
                    w_idx_nxt   = '0;
`endif
                end
            end
            ARM: begin
                if (w_rise) begin
                    w_state_nxt = MEAS;
                    w_cnt_nxt   = ACC_W'(1);
                end else if (r_cnt == LIMIT) begin
                    w_state_nxt = DONE;
                    w_abort     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + ACC_W'(1);
                end
            end
            MEAS: begin
                if (w_rise && w_last_rise) begin
                    w_state_nxt = DONE;
                    w_capture   = 1'b1;
                end else if (w_rise) begin
                    w_cnt_nxt   = r_cnt + ACC_W'(1);
`ifdef MULTI_PERIOD_EN
                    w_idx_nxt   = r_idx + NPER_LOG2'(1);
`endif
                end else if (r_cnt == LIMIT) begin
                    w_state_nxt = DONE;
                    w_abort     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + ACC_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Result registers only load on the transition into DONE, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_period    <= '0;
            r_div_code  <= '0;
            r_div_match <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= w_capture | w_abort;
            if (r_state == IDLE && start) begin
                r_busy <= 1'b1;
            end else if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
            if (w_capture) begin
                r_period    <= w_result;
                r_div_code  <= (w_class.match && w_exact) ? w_class.code : '0;
                r_div_match <= w_class.match & w_exact;
                r_timeout   <= 1'b0;
            end else if (w_abort) begin
                r_period    <= CNT_W'(TIMEOUT);
                r_div_code  <= '0;
                r_div_match <= 1'b0;
                r_timeout   <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign period    = r_period;
    assign div_code  = r_div_code;
    assign div_match = r_div_match;
    assign timeout   = r_timeout;

endmodule
